instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/sequencer_pkg.sv | 32 +++
 rtl/op_classify.sv | 26 ++
 rtl/instr_sequencer.sv | 108 ++++++++++
 tb/tb_instr_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared constants and types for the instruction sequencer.
package sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Opcodes 0000..OP_ALU_MAX are ALU operations
  localparam logic [3:0] OP_ALU_MAX = 4'b0111;
  localparam logic [3:0] OP_LOAD    = 4'b1000;
  localparam logic [3:0] OP_STORE   = 4'b1001;
  localparam logic [3:0] OP_BRANCH  = 4'b1010;
  localparam logic [3:0] OP_JUMP    = 4'b1011;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  // One-hot instruction class
  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic nop;
    logic halt;
  } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: 4-bit opcode in, one-hot class out.
module op_classify
  import sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  cls
);

  // Exactly one class bit is set for every opcode; unlisted upper codes are NOPs
  always_comb begin
    cls = '0;
    if (opcode <= OP_ALU_MAX) begin
      cls.alu = 1'b1;
    end else begin
      case (opcode)
        OP_LOAD:   cls.load   = 1'b1;
        OP_STORE:  cls.store  = 1'b1;
        OP_BRANCH: cls.branch = 1'b1;
        OP_JUMP:   cls.jump   = 1'b1;
        OP_HALT:   cls.halt   = 1'b1;
        default:   cls.nop    = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback.
//
// state  | meaning
// FETCH  | imem_req high at PC, wait for imem_ack, latch ir, PC+1
// DECODE | classify ir, resolve branch/jump PC, pick next state
// EXEC   | one-cycle ALU strobe
// MEM    | dmem_req high until dmem_ack (dmem_we for STORE)
// WB     | one-cycle register-file write strobe
// HALT   | absorbing stop, only rst leaves
//
// Every output is a decode of registered state, so no input reaches an
// output combinationally.
module instr_sequencer
  import sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [9:0] imem_data,
  output logic [9:0] ir,
  output logic       alu_en,
  output logic       rf_we,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  input  logic       cond,
  output logic [2:0] state,
  output logic       halted
);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [9:0] ir_q, ir_d;
  op_class_t  cls;

  op_classify u_op_classify (
    .opcode (ir_q[9:6]),
    .cls    (cls)
  );

  // State, PC and instruction register; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= 8'd0;
      ir_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC and ir update; holds everything by default
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (cls.halt) begin
          state_d = HALT;
        end else if (cls.alu) begin
          state_d = EXEC;
        end else if (cls.load || cls.store) begin
          state_d = MEM;
        end else if (cls.branch || cls.jump || cls.nop) begin
          state_d = FETCH;
          // PC already points past the branch, so the offset is relative to PC+1
          if (cls.branch && cond) begin
            pc_d = pc_q + {{2{ir_q[5]}}, ir_q[5:0]};
          end else if (cls.jump) begin
            pc_d = {2'b00, ir_q[5:0]};
          end
        end
      end
      EXEC:    state_d = WB;
      MEM: begin
        if (dmem_ack) begin
          state_d = cls.store ? FETCH : WB;
        end
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  assign state     = state_q;
  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign alu_en    = (state_q == EXEC);
  assign rf_we     = (state_q == WB);
  assign dmem_req  = (state_q == MEM);
  assign dmem_we   = (state_q == MEM) && cls.store;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus a
// randomized instruction stream checked against an instruction-level model.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [9:0] imem_data = 10'd0;
  logic [9:0] ir;
  logic       alu_en;
  logic       rf_we;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack = 1'b0;
  logic       cond = 1'b0;
  logic [2:0] state;
  logic       halted;

  int checks = 0;
  int errors = 0;

  instr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .ir        (ir),
    .alu_en    (alu_en),
    .rf_we     (rf_we),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .cond      (cond),
    .state     (state),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Plays memory for one instruction starting in FETCH. Returns what was
  // observed until the sequencer is back in FETCH (or reaches HALT).
  task automatic exec_instr(input logic [9:0] instr, input int iw, input int dw, input logic c,
                            output int cyc, output int n_alu, output int n_rf,
                            output int n_dreq, output int n_dwe, output logic [7:0] faddr,
                            output bit addr_stable, output bit timeout);
    int waited = 0;
    int dwaited = 0;
    bit fetched = 0;
    cyc = 0; n_alu = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
    faddr = imem_addr;
    addr_stable = 1;
    timeout = 1;
    cond = c;
    for (int g = 0; g < 100; g++) begin
      cyc++;
      n_alu += int'(alu_en);
      n_rf  += int'(rf_we);
      if (dmem_req) begin
        n_dreq++;
        n_dwe += int'(dmem_we);
      end
      dmem_ack = 1'b0;
      if (state == 3'd0) begin
        if (imem_addr !== faddr || imem_req !== 1'b1) addr_stable = 0;
        if (waited == iw) begin
          imem_ack = 1'b1;
          imem_data = instr;
          fetched = 1;
        end else begin
          imem_ack = 1'b0;
          imem_data = 10'($urandom);
          waited++;
        end
      end else begin
        // stray acks with garbage data outside FETCH must be ignored
        imem_ack = 1'($urandom_range(0, 1));
        imem_data = 10'($urandom);
      end
      if (state == 3'd3) begin
        if (dwaited == dw) dmem_ack = 1'b1;
        else dwaited++;
      end
      step();
      if (fetched && (state == 3'd0 || state == 3'd5)) begin
        timeout = 0;
        break;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  // Instruction-level reference: cycles, strobe counts and next PC
  task automatic model(input logic [9:0] instr, input int iw, input int dw, input logic c,
                       input int pc, output int cyc, output int n_alu, output int n_rf,
                       output int n_dreq, output int n_dwe, output int npc);
    int op;
    int off;
    op = int'(instr[9:6]);
    off = instr[5] ? int'(instr[5:0]) - 64 : int'(instr[5:0]);
    n_alu = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
    npc = (pc + 1) % 256;
    if (op < 8) begin
      cyc = 4 + iw; n_alu = 1; n_rf = 1;
    end else if (op == 8) begin
      cyc = 4 + iw + dw; n_dreq = dw + 1; n_rf = 1;
    end else if (op == 9) begin
      cyc = 3 + iw + dw; n_dreq = dw + 1; n_dwe = dw + 1;
    end else if (op == 10) begin
      cyc = 2 + iw;
      if (c) npc = (pc + 1 + off + 256) % 256;
    end else if (op == 11) begin
      cyc = 2 + iw;
      npc = int'(instr[5:0]);
    end else begin
      cyc = 2 + iw;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 3'd0 || imem_addr !== 8'd0 || ir !== 10'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: state=%0d pc=%0d ir=%h halted=%b, want 0 0 000 0", state, imem_addr, ir, halted);
    end
    checks++;
    if (imem_req !== 1'b1 || alu_en !== 1'b0 || rf_we !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: imem_req=%b alu=%b rf=%b dreq=%b dwe=%b, want 1 0 0 0 0",
               imem_req, alu_en, rf_we, dmem_req, dmem_we);
    end
  endtask

  task automatic test_alu();
    int exp_st[5] = '{0, 1, 2, 4, 0};
    bit exp_alu[5] = '{0, 0, 1, 0, 0};
    bit exp_rf[5] = '{0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (int'(state) != exp_st[i] || alu_en !== exp_alu[i] || rf_we !== exp_rf[i]) begin
        errors++;
        $display("FAIL alu_cycle%0d: state=%0d alu_en=%b rf_we=%b, want %0d %b %b",
                 i + 1, state, alu_en, rf_we, exp_st[i], exp_alu[i], exp_rf[i]);
      end
      imem_ack = (i == 0);
      imem_data = 10'b0000000100;
      if (i < 4) step();
    end
    imem_ack = 1'b0;
    checks++;
    if (imem_addr !== 8'd1 || ir !== 10'b0000000100) begin
      errors++;
      $display("FAIL alu_pc_ir: pc=%0d ir=%b, want 1 0000000100", imem_addr, ir);
    end
  endtask

  task automatic test_load_store();
    int cyc, na, nr, nd, nw;
    logic [7:0] fa;
    bit st, to;
    do_reset();
    exec_instr(10'b1000000011, 0, 3, 1'b0, cyc, na, nr, nd, nw, fa, st, to);
    checks++;
    if (to || cyc != 7 || nd != 4 || nw != 0 || nr != 1 || na != 0) begin
      errors++;
      $display("FAIL load_delay3: to=%0d cyc=%0d dreq=%0d dwe=%0d rf=%0d alu=%0d, want 0 7 4 0 1 0",
               to, cyc, nd, nw, nr, na);
    end
    do_reset();
    exec_instr(10'b1001000011, 0, 3, 1'b0, cyc, na, nr, nd, nw, fa, st, to);
    checks++;
    if (to || cyc != 6 || nd != 4 || nw != 4 || nr != 0 || na != 0) begin
      errors++;
      $display("FAIL store_delay3: to=%0d cyc=%0d dreq=%0d dwe=%0d rf=%0d alu=%0d, want 0 6 4 4 0 0",
               to, cyc, nd, nw, nr, na);
    end
  endtask

  task automatic test_branch();
    int cyc, na, nr, nd, nw;
    logic [7:0] fa;
    bit st, to;
    do_reset();
    exec_instr(10'b1010111110, 0, 0, 1'b1, cyc, na, nr, nd, nw, fa, st, to);
    checks++;
    if (to || cyc != 2 || imem_addr !== 8'd255) begin
      errors++;
      $display("FAIL branch_taken: to=%0d cyc=%0d next_addr=%0d, want 0 2 255", to, cyc, imem_addr);
    end
    do_reset();
    exec_instr(10'b1010111110, 0, 0, 1'b0, cyc, na, nr, nd, nw, fa, st, to);
    checks++;
    if (to || cyc != 2 || imem_addr !== 8'd1) begin
      errors++;
      $display("FAIL branch_not_taken: to=%0d cyc=%0d next_addr=%0d, want 0 2 1", to, cyc, imem_addr);
    end
  endtask

  task automatic test_jump_nop_wrap();
    int cyc, na, nr, nd, nw;
    int total = 0;
    bit any_to = 0;
    logic [7:0] fa;
    bit st, to;
    do_reset();
    exec_instr(10'b1011101010, 0, 0, 1'b0, cyc, na, nr, nd, nw, fa, st, to);
    checks++;
    if (to || cyc != 2 || imem_addr !== 8'd42) begin
      errors++;
      $display("FAIL jump: to=%0d cyc=%0d next_addr=%0d, want 0 2 42", to, cyc, imem_addr);
    end
    do_reset();
    for (int i = 0; i < 256; i++) begin
      exec_instr(10'b1100000000 | 10'(i % 3) << 6, 0, 0, 1'b0, cyc, na, nr, nd, nw, fa, st, to);
      total += cyc;
      any_to |= to;
    end
    checks++;
    if (any_to || total != 512 || imem_addr !== 8'd0) begin
      errors++;
      $display("FAIL nop_wrap: to=%0d cycles=%0d pc=%0d, want 0 512 0", any_to, total, imem_addr);
    end
  endtask

  task automatic test_halt();
    int cyc, na, nr, nd, nw;
    int bad = 0;
    logic [7:0] fa;
    bit st, to;
    do_reset();
    exec_instr(10'b1111000000, 1, 0, 1'b0, cyc, na, nr, nd, nw, fa, st, to);
    checks++;
    if (to || state !== 3'd5 || halted !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: to=%0d state=%0d halted=%b imem_req=%b, want 0 5 1 0", to, state, halted, imem_req);
    end
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_data = 10'($urandom);
      dmem_ack = 1'($urandom_range(0, 1));
      cond = 1'($urandom_range(0, 1));
      step();
      if (state !== 3'd5 || halted !== 1'b1 || imem_req !== 1'b0 || alu_en !== 1'b0 || rf_we !== 1'b0 ||
          dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_addr !== 8'd1 || ir !== 10'b1111000000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold: bad_cycles=%0d, want 0", bad);
    end
    imem_ack = 1'b1;
    imem_data = 10'h155;
    do_reset();
    checks++;
    if (state !== 3'd0 || imem_addr !== 8'd0 || halted !== 1'b0 || ir !== 10'd0) begin
      errors++;
      $display("FAIL halt_reset: state=%0d pc=%0d halted=%b ir=%h, want 0 0 0 000", state, imem_addr, halted, ir);
    end
  endtask

  task automatic test_reset_mid_mem();
    int bad = 0;
    do_reset();
    imem_ack = 1'b1;
    imem_data = 10'b1000000011;
    step();
    imem_ack = 1'b0;
    step();
    step();
    checks++;
    if (state !== 3'd3 || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_setup: state=%0d dmem_req=%b, want 3 1", state, dmem_req);
    end
    rst = 1'b1;
    dmem_ack = 1'b1;
    step();
    rst = 1'b0;
    dmem_ack = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || state !== 3'd0 || rf_we !== 1'b0 || ir !== 10'd0) begin
      errors++;
      $display("FAIL mid_mem_reset: dmem_req=%b state=%0d rf_we=%b ir=%h, want 0 0 0 000", dmem_req, state, rf_we, ir);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (rf_we !== 1'b0 || state !== 3'd0 || imem_req !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_mem_after: bad_cycles=%0d, want 0", bad);
    end
  endtask

  task automatic test_random();
    int cyc, na, nr, nd, nw;
    int ecyc, ena, enr, end_, enw, npc;
    int pc = 0;
    int iw, dw;
    logic [7:0] fa;
    logic [9:0] instr;
    logic c;
    bit st, to;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      instr = {4'($urandom_range(0, 14)), 6'($urandom)};
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      c = 1'($urandom_range(0, 1));
      model(instr, iw, dw, c, pc, ecyc, ena, enr, end_, enw, npc);
      exec_instr(instr, iw, dw, c, cyc, na, nr, nd, nw, fa, st, to);
      checks++;
      if (to || int'(fa) != pc || !st || ir !== instr) begin
        errors++;
        $display("FAIL rand%0d_fetch: instr=%b to=%0d addr=%0d stable=%0d ir=%b, want addr %0d stable 1",
                 n, instr, to, fa, st, ir, pc);
      end
      checks++;
      if (cyc != ecyc || na != ena || nr != enr || nd != end_ || nw != enw) begin
        errors++;
        $display("FAIL rand%0d_timing: instr=%b iw=%0d dw=%0d c=%b cyc/alu/rf/dreq/dwe=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                 n, instr, iw, dw, c, cyc, na, nr, nd, nw, ecyc, ena, enr, end_, enw);
      end
      pc = npc;
    end
    checks++;
    if (int'(imem_addr) != pc) begin
      errors++;
      $display("FAIL rand_final_pc: pc=%0d, want %0d", imem_addr, pc);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jump_nop_wrap();
    test_halt();
    test_reset_mid_mem();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
